seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller for the RTC display path. It replaces the fixed six-digit driver with a configurable number of digits and hex decoding. It adds per-digit blink and decimal-point masks, and tear-free frame-synchronous loading of new display data. It sits between the RTC control block's time output and the board's `seg`/`sel` pins.

---
 rtl/seg_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Scans NUM_DIG digits with a fixed dwell, decodes 4-bit hex nibbles,
// applies per-digit blink and decimal-point masks, and double-buffers the
// display data so a new value only takes effect at a frame boundary.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst     in   asynchronous active-high reset
//   data_in     in   4 bits per digit, digit 0 in the low nibble (rightmost)
//   blink_mask  in   per-digit blink enable
//   dp_mask     in   per-digit decimal point enable
//   data_vld    in   one-cycle load strobe for data_in/blink_mask/dp_mask
//   sel         out  digit enables, active-low, one-cold (registered)
//   seg         out  {dp,g,f,e,d,c,b,a}, active-low (registered)
//   frame_done  out  one-cycle pulse when digit 0 of a new frame is shown
//
// Build option: define SEG_LZB_EN for leading-zero blanking.

module seg_scan_ctrl #(
    parameter int unsigned NUM_DIG   = 6,
    parameter int unsigned CNT_SCAN  = 49_999,
    parameter int unsigned CNT_BLINK = 12_499_999
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     blink_mask,
    input  logic [NUM_DIG-1:0]     dp_mask,
    input  logic                   data_vld,
    output logic [NUM_DIG-1:0]     sel,
    output logic [7:0]             seg,
    output logic                   frame_done
);

    localparam int unsigned DATA_W  = 4 * NUM_DIG;
    localparam int unsigned SCAN_W  = (CNT_SCAN  > 0) ? $clog2(CNT_SCAN + 1)  : 1;
    localparam int unsigned BLINK_W = (CNT_BLINK > 0) ? $clog2(CNT_BLINK + 1) : 1;
    localparam int unsigned IDX_W   = (NUM_DIG   > 1) ? $clog2(NUM_DIG)       : 1;

    // Display payload shared by the pending and active buffers
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [NUM_DIG-1:0] blink;
        logic [NUM_DIG-1:0] dp;
    } disp_t;

    // Active-low {g,f,e,d,c,b,a} glyph for a hex nibble
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q,  blink_ph_d;
    disp_t              act_q,       act_d;
    disp_t              pend_q,      pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic               wrap_q,      wrap_d;
    logic [NUM_DIG-1:0] sel_q,       sel_d;
    logic [7:0]         seg_q,       seg_d;
    logic               frame_done_q, frame_done_d;

    logic               scan_end;
    logic               last_dig;
    logic               frame_end;
    disp_t              load_c;
    logic [3:0]         cur_nib;
    logic               cur_blink;
    logic               cur_dp;

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            wrap_q       <= 1'b0;
            sel_q        <= '1;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            wrap_q       <= wrap_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        scan_end     = (scan_cnt_q == SCAN_W'(CNT_SCAN));
        last_dig     = (idx_q == IDX_W'(NUM_DIG - 1));
        frame_end    = scan_end && last_dig;
        load_c       = {data_in, blink_mask, dp_mask};
        cur_nib      = 4'(act_q.data >> {idx_q, 2'b00});
        cur_blink    = 1'(act_q.blink >> idx_q);
        cur_dp       = 1'(act_q.dp >> idx_q);

        scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
        idx_d        = idx_q;
        blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
        blink_ph_d   = blink_ph_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        wrap_d       = frame_end;
        frame_done_d = wrap_q;
        sel_d        = ~(NUM_DIG'(1) << idx_q);
        seg_d        = {~cur_dp, hex_glyph(cur_nib)};

        // Dwell counter and digit index
        if (scan_end) begin
            scan_cnt_d = '0;
            idx_d      = last_dig ? '0 : idx_q + IDX_W'(1);
        end

        // Free-running blink phase
        if (blink_cnt_q == BLINK_W'(CNT_BLINK)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end

        // Last strobe of a frame wins; a strobe on the boundary bypasses pending
        if (data_vld) begin
            pend_d = load_c;
        end
        if (frame_end) begin
            pend_flag_d = 1'b0;
            if (data_vld) begin
                act_d = load_c;
            end else if (pend_flag_q) begin
                act_d = pend_q;
            end
        end else if (data_vld) begin
            pend_flag_d = 1'b1;
        end

`ifdef SEG_LZB_EN
        // Blank a zero digit with only zeros above it, unless its dp is lit
        if ((idx_q != '0) && !cur_dp && ((act_q.data >> {idx_q, 2'b00}) == '0)) begin
            seg_d = 8'hFF;
        end
`endif

        if (cur_blink && blink_ph_q) begin
            seg_d = 8'hFF;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (NUM_DIG=4, CNT_SCAN=3, CNT_BLINK=31).
// Expected outputs come from a cycle-indexed model: after reset release,
// edge k shows digit ((k-1)/4)%4 with blink phase ((k-1)/32)%2, and the
// active buffer changes at edges that are multiples of 16.

module tb_seg_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned FRAME = 16;
    localparam int unsigned HALF  = 32;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [15:0] data_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        data_vld;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    seg_scan_ctrl #(
        .NUM_DIG   (ND),
        .CNT_SCAN  (3),
        .CNT_BLINK (31)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_in),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .data_vld   (data_vld),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int          k;
    logic [15:0] m_act_d,  m_pend_d;
    logic [3:0]  m_act_bm, m_pend_bm;
    logic [3:0]  m_act_dm, m_pend_dm;
    logic        m_pend_f;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0; 4'h1: g = 8'hF9; 4'h2: g = 8'hA4; 4'h3: g = 8'hB0;
            4'h4: g = 8'h99; 4'h5: g = 8'h92; 4'h6: g = 8'h82; 4'h7: g = 8'hF8;
            4'h8: g = 8'h80; 4'h9: g = 8'h90; 4'hA: g = 8'h88; 4'hB: g = 8'h83;
            4'hC: g = 8'hC6; 4'hD: g = 8'hA1; 4'hE: g = 8'h86; default: g = 8'h8E;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] model_seg(input int d, input logic ph);
        logic [15:0] hi;
        logic [7:0]  r;
        hi = m_act_d >> (4 * d);
        if (m_act_bm[d] && ph) return 8'hFF;
`ifdef SEG_LZB_EN
        if (d > 0 && hi == 16'h0 && !m_act_dm[d]) return 8'hFF;
`endif
        r    = glyph(hi[3:0]);
        r[7] = ~m_act_dm[d];
        return r;
    endfunction

    function automatic logic is_fd(input int kk);
        return (kk > 1) && ((kk - 1) % FRAME == 0);
    endfunction

    task automatic model_clear();
        k = 0;
        m_act_d = '0; m_act_bm = '0; m_act_dm = '0;
        m_pend_d = '0; m_pend_bm = '0; m_pend_dm = '0;
        m_pend_f = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s (edge %0d): got %h, want %h", name, k, act, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare all outputs
    task automatic step(input logic vld, input logic [15:0] d,
                        input logic [3:0] bm, input logic [3:0] dm);
        int         dig;
        logic       ph;
        logic [3:0] one;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic       e_fd;
        data_vld   = vld;
        data_in    = d;
        blink_mask = bm;
        dp_mask    = dm;
        @(posedge sys_clk);
        k++;
        dig   = ((k - 1) / DWELL) % ND;
        ph    = 1'(((k - 1) / HALF) % 2);
        one   = 4'b0001;
        e_sel = ~(one << dig);
        e_seg = model_seg(dig, ph);
        e_fd  = is_fd(k);
        if (k % FRAME == 0) begin
            if (vld) begin
                m_act_d = d; m_act_bm = bm; m_act_dm = dm;
            end else if (m_pend_f) begin
                m_act_d = m_pend_d; m_act_bm = m_pend_bm; m_act_dm = m_pend_dm;
            end
            m_pend_f = 1'b0;
        end else if (vld) begin
            m_pend_d = d; m_pend_bm = bm; m_pend_dm = dm;
            m_pend_f = 1'b1;
        end
        #1;
        vec_cnt++;
        if (sel !== e_sel || seg !== e_seg || frame_done !== e_fd) begin
            err_cnt++;
            $display("FAIL step (edge %0d): sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                     k, sel, seg, frame_done, e_sel, e_seg, e_fd);
        end
        data_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, data_in, blink_mask, dp_mask);
    endtask

    // Advance until the model's last edge was a frame_done edge
    task automatic run_to_fd(input string name);
        int n;
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!is_fd(k) && n < 40);
        if (!is_fd(k)) check({name, "_timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        tbl[0] = '{16'h12AF, 4'b0000, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
        tbl[1] = '{16'h3456, 4'b0100, {8'hB0, 8'h19, 8'h92, 8'h82}};
        tbl[2] = '{16'h789B, 4'b1111, {8'h78, 8'h00, 8'h10, 8'h03}};
        tbl[3] = '{16'hCDE0, 4'b0000, {8'hC6, 8'hA1, 8'h86, 8'hC0}};
`ifdef SEG_LZB_EN
        tbl[4] = '{16'h0005, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
        tbl[5] = '{16'h0005, 4'b0010, {8'hFF, 8'hFF, 8'h40, 8'h92}};
        tbl[6] = '{16'h00A0, 4'b0000, {8'hFF, 8'hFF, 8'h88, 8'hC0}};
        tbl[7] = '{16'h0000, 4'b1000, {8'h40, 8'hFF, 8'hFF, 8'hC0}};
`else
        tbl[4] = '{16'h0005, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'h92}};
        tbl[5] = '{16'h0005, 4'b0010, {8'hC0, 8'hC0, 8'h40, 8'h92}};
        tbl[6] = '{16'h00A0, 4'b0000, {8'hC0, 8'hC0, 8'h88, 8'hC0}};
        tbl[7] = '{16'h0000, 4'b1000, {8'h40, 8'hC0, 8'hC0, 8'hC0}};
`endif

        data_in = '0; blink_mask = '0; dp_mask = '0; data_vld = 1'b0;
        model_clear();

        // Reset state
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_out", 32'({sel, seg, frame_done}), 32'({4'hF, 8'hFF, 1'b0}));
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Idle scan: first edge shows digit 0 as "0"
        idle(1);
        check("first_sel", 32'(sel), 32'(4'hE));
        check("first_seg", 32'(seg), 32'(8'hC0));
        idle(47);

        // Decode table: each value shown from the next frame_done onward
        for (int r = 0; r < 8; r++) begin
            step(1'b1, tbl[r].data, 4'b0000, tbl[r].dp);
            run_to_fd("tbl_fd");
            for (int c = 0; c < int'(FRAME); c++) begin
                if (c > 0) idle(1);
                check($sformatf("tbl%0d_dig%0d", r, ((k - 1) / DWELL) % ND),
                      32'(seg), 32'(tbl[r].exp[((k - 1) / DWELL) % ND]));
            end
        end

        // Two strobes in one frame: the later one is displayed
        while (k % FRAME != 3) idle(1);
        step(1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(3);
        step(1'b1, 16'h2222, 4'b0000, 4'b0000);
        run_to_fd("two_fd");
        check("two_strobe_seg", 32'(seg), 32'(8'hA4));

        // Boundary strobe overrides a pending one and shows in the frame_done cycle
        while (k % FRAME != 3) idle(1);
        step(1'b1, 16'h4444, 4'b0000, 4'b0000);
        while ((k + 1) % FRAME != 0) idle(1);
        step(1'b1, 16'h3333, 4'b0000, 4'b0000);
        idle(1);
        check("bnd_fd", 32'(frame_done), 32'(1));
        check("bnd_seg", 32'(seg), 32'(8'hB0));
        idle(int'(FRAME));
        check("bnd_nopend", 32'(seg), 32'(8'hB0));

        // Blink on digit 1, dp on digit 2
        step(1'b1, 16'h1234, 4'b0010, 4'b0100);
        idle(100);

        // Reset mid-dwell with a load pending
        while (k % FRAME != 5) idle(1);
        step(1'b1, 16'h789A, 4'hF, 4'hF);
        idle(1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_async", 32'({sel, seg, frame_done}), 32'({4'hF, 8'hFF, 1'b0}));
        @(posedge sys_clk);
        #1;
        check("rst_hold", 32'({sel, seg, frame_done}), 32'({4'hF, 8'hFF, 1'b0}));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_clear();
        idle(1);
        check("post_rst_seg", 32'(seg), 32'(8'hC0));
        idle(40);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 7) == 0),
                 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
